dmem_resp: RTL and testbench



---
 rtl/dmem_resp_pkg.sv | 13 +
 rtl/dmem_resp_if.sv | 15 +
 rtl/dmem_ram.sv | 25 ++
 rtl/dmem_resp.sv | 88 ++++++++
 tb/tb_dmem_resp.sv | 130 +++++++++++++
 5 files changed

// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: bus types, hold levels, FSM encodings and the address error check shared by the data-memory responder
package dmem_resp_pkg;
  typedef logic [31:0] MemBus;
  typedef logic [31:0] MemAddrBus;
  typedef logic [3:0] MemUnit;
  localparam MemBus ZeroWord = '0;
  localparam logic HoldEnable = 1'b1;
  localparam logic HoldDisable = 1'b0;
  typedef enum logic [1:0] {DMEM_IDLE, DMEM_WAIT, DMEM_RESP} dmem_state_e;
  function automatic logic addr_err(input MemAddrBus a, input MemAddrBus base, input logic [32:0] span);
    return (a[1:0] != 2'b00) || (a < base) || ({1'b0, a} >= {1'b0, base} + span);
  endfunction
endpackage

// File: rtl/dmem_resp_if.sv
// dmem_resp_if: load/store request bus (cs, we, byte mask, data, address) and response (rdata, ack, err, hold); master = execute stage, slave = responder
interface dmem_resp_if;
  import dmem_resp_pkg::*;
  logic cs_i;
  logic mem_we_i;
  MemUnit mem_wem_i;
  MemBus mem_din_i;
  MemAddrBus mem_addr_i;
  MemBus rdata_o;
  logic ack_o;
  logic err_o;
  logic hold_flag_o;
  modport master(output cs_i, mem_we_i, mem_wem_i, mem_din_i, mem_addr_i, input rdata_o, ack_o, err_o, hold_flag_o);
  modport slave(input cs_i, mem_we_i, mem_wem_i, mem_din_i, mem_addr_i, output rdata_o, ack_o, err_o, hold_flag_o);
endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH x 32 single-port RAM, byte write enables, registered read (i_kill blocks the write and zeroes the read)
module dmem_ram import dmem_resp_pkg::*; #(
  parameter int DEPTH = 4096,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic i_rst,
  input logic i_en,
  input logic i_we,
  input logic i_kill,
  input MemUnit i_wem,
  input logic [AW-1:0] i_idx,
  input MemBus i_din,
  output MemBus o_dout
);
  MemBus r_mem [DEPTH];
  MemBus r_dout;
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (i_en & i_we & ~i_kill & i_wem[i]) r_mem[i_idx][8*i +: 8] <= i_din[8*i +: 8];
  always_ff @(posedge clk)
    if (i_rst) r_dout <= ZeroWord;
    else if (i_en & ~i_we) r_dout <= i_kill ? ZeroWord : r_mem[i_idx];
  assign o_dout = r_dout;
endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder (clk, rstn active-high sync reset, bus slave); IDLE/WAIT/RESP FSM with WAIT_CYCLES wait states, optional DMEM_ERR_CHK_EN address check
module dmem_resp import dmem_resp_pkg::*; #(
  parameter int DEPTH = 4096,
  parameter int WAIT_CYCLES = 0,
  parameter MemAddrBus BASE_ADDR = 32'h0000_0000
) (
  input logic clk,
  input logic rstn,
  dmem_resp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  dmem_state_e r_state;
  logic [3:0] r_cnt;
  logic r_we, r_ack, r_err;
  MemUnit r_wem;
  MemBus r_din;
  logic [AW-1:0] r_idx;
  logic w_idle, w_go, w_we, w_err, w_err_now;
  MemUnit w_wem;
  MemBus w_din;
  logic [AW-1:0] w_idx;
`ifdef DMEM_ERR_CHK_EN
  assign w_err_now = addr_err(bus.mem_addr_i, BASE_ADDR, 33'(DEPTH) << 2);
`else
  logic w_unused;
  assign w_err_now = 1'b0;
  assign w_unused = ^{bus.mem_addr_i[31:AW+2], bus.mem_addr_i[1:0]};
`endif
  // the RAM acts on the edge that enters RESP: live inputs when accepting straight from IDLE, captured ones from WAIT
  always_comb begin
    w_idle = r_state == DMEM_IDLE;
    w_go = ~rstn & (w_idle ? (bus.cs_i & (WAIT_CYCLES == 0)) : ((r_state == DMEM_WAIT) & (r_cnt == 4'd0)));
    w_we = w_idle ? bus.mem_we_i : r_we;
    w_wem = w_idle ? bus.mem_wem_i : r_wem;
    w_din = w_idle ? bus.mem_din_i : r_din;
    w_idx = w_idle ? bus.mem_addr_i[AW+1:2] : r_idx;
    w_err = w_idle ? w_err_now : r_err;
  end
  always_ff @(posedge clk)
    if (rstn) begin
      r_state <= DMEM_IDLE;
      r_cnt <= 4'd0;
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        DMEM_IDLE: if (bus.cs_i) begin
          r_we <= bus.mem_we_i;
          r_wem <= bus.mem_wem_i;
          r_din <= bus.mem_din_i;
          r_idx <= bus.mem_addr_i[AW+1:2];
          r_err <= w_err_now;
          r_state <= WAIT_CYCLES > 0 ? DMEM_WAIT : DMEM_RESP;
          r_cnt <= 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
          r_ack <= WAIT_CYCLES == 0;
        end
        DMEM_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd0) begin
            r_state <= DMEM_RESP;
            r_ack <= 1'b1;
          end
        end
        default: begin
          r_state <= DMEM_IDLE;
          r_ack <= 1'b0;
        end
      endcase
    end
  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .i_rst(rstn),
    .i_en(w_go),
    .i_we(w_we),
    .i_kill(w_err),
    .i_wem(w_wem),
    .i_idx(w_idx),
    .i_din(w_din),
    .o_dout(bus.rdata_o)
  );
  assign bus.ack_o = r_ack;
`ifdef DMEM_ERR_CHK_EN
  assign bus.err_o = r_ack & r_err;
`else
  assign bus.err_o = 1'b0;
`endif
  assign bus.hold_flag_o = (~rstn & ((w_idle & bus.cs_i) | (r_state == DMEM_WAIT))) ? HoldEnable : HoldDisable;
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed table-driven bench for dmem_resp with a zero-wait and a three-wait instance
module tb_dmem_resp;
  import dmem_resp_pkg::*;
  typedef struct {
    bit sel;
    bit we;
    logic [3:0] wem;
    logic [31:0] din;
    logic [31:0] addr;
    logic [31:0] rdata;
    bit err;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic sel = 1'b0;
  logic cs = 1'b0;
  logic we = 1'b0;
  logic [3:0] wem = '0;
  logic [31:0] din = '0;
  logic [31:0] addr = '0;
  logic w_ack, w_err, w_hold;
  logic [31:0] w_rdata;
  int pass = 0;
  int total = 0;
  vec_t v[$];
  always #5 clk = ~clk;
  dmem_resp_if if0();
  dmem_resp_if if1();
  assign if0.cs_i = cs & ~sel;
  assign if1.cs_i = cs & sel;
  assign if0.mem_we_i = we;
  assign if1.mem_we_i = we;
  assign if0.mem_wem_i = wem;
  assign if1.mem_wem_i = wem;
  assign if0.mem_din_i = din;
  assign if1.mem_din_i = din;
  assign if0.mem_addr_i = addr;
  assign if1.mem_addr_i = addr;
  assign w_ack = sel ? if1.ack_o : if0.ack_o;
  assign w_err = sel ? if1.err_o : if0.err_o;
  assign w_hold = sel ? if1.hold_flag_o : if0.hold_flag_o;
  assign w_rdata = sel ? if1.rdata_o : if0.rdata_o;
  dmem_resp #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
  dmem_resp #(.DEPTH(16), .WAIT_CYCLES(3)) u_dut1 (.clk(clk), .rstn(rstn), .bus(if1.slave));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  function automatic vec_t mk(bit s, bit w, logic [3:0] m, logic [31:0] d, logic [31:0] a, logic [31:0] r, bit e);
    vec_t t;
    t.sel = s; t.we = w; t.wem = m; t.din = d; t.addr = a; t.rdata = r; t.err = e;
    return t;
  endfunction
  task automatic xfer(input vec_t t, input string n);
    int lat, hc;
    bit got;
    logic h_ack, er;
    logic [31:0] rd;
    @(negedge clk);
    sel = t.sel; we = t.we; wem = t.wem; din = t.din; addr = t.addr; cs = 1'b1;
    lat = 99; hc = 0; got = 0; h_ack = 1'b1; er = 1'b1; rd = 'x;
    for (int i = 0; i < 20 && !got; i++) begin
      #1 if (w_hold) hc++;
      @(negedge clk);
      if (w_ack) begin
        got = 1; lat = i + 1; rd = w_rdata; er = w_err; h_ack = w_hold; cs = 1'b0;
      end
    end
    cs = 1'b0;
    chk({n, " latency"}, lat, t.sel ? 4 : 1);
    chk({n, " hold cycles"}, hc, t.sel ? 4 : 1);
    chk({n, " hold in ack"}, {31'b0, h_ack}, 0);
    chk({n, " rdata"}, rd, t.rdata);
    chk({n, " err"}, {31'b0, er}, {31'b0, t.err});
  endtask
  initial begin
    int n_ack;
    rstn = 1'b1; cs = 1'b1; sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset hold0", {31'b0, if0.hold_flag_o}, 0);
    chk("reset ack0", {31'b0, if0.ack_o}, 0);
    chk("reset err0", {31'b0, if0.err_o}, 0);
    chk("reset rdata0", if0.rdata_o, 0);
    chk("reset ack1", {31'b0, if1.ack_o}, 0);
    chk("reset rdata1", if1.rdata_o, 0);
    cs = 1'b0; rstn = 1'b0;
    v.push_back(mk(0, 1, 4'hF, 32'hDEADBEEF, 32'h10, 32'h0, 0));
    v.push_back(mk(0, 0, 4'h0, 32'h0, 32'h10, 32'hDEADBEEF, 0));
    v.push_back(mk(0, 1, 4'hF, 32'h11223344, 32'h20, 32'hDEADBEEF, 0));
    v.push_back(mk(0, 1, 4'b0101, 32'hAABBCCDD, 32'h20, 32'hDEADBEEF, 0));
    v.push_back(mk(0, 0, 4'hF, 32'h0, 32'h20, 32'h11BB33DD, 0));
    v.push_back(mk(0, 1, 4'hF, 32'hCAFEF00D, 32'h24, 32'h11BB33DD, 0));
    v.push_back(mk(0, 1, 4'h0, 32'h0, 32'h24, 32'h11BB33DD, 0));
    v.push_back(mk(0, 0, 4'h0, 32'h0, 32'h24, 32'hCAFEF00D, 0));
`ifdef DMEM_ERR_CHK_EN
    v.push_back(mk(0, 1, 4'hF, 32'h01020304, 32'h30, 32'hCAFEF00D, 0));
    v.push_back(mk(0, 1, 4'hF, 32'hFFFFFFFF, 32'h32, 32'hCAFEF00D, 1));
    v.push_back(mk(0, 0, 4'h0, 32'h0, 32'h30, 32'h01020304, 0));
    v.push_back(mk(0, 0, 4'h0, 32'h0, 32'h40, 32'h0, 1));
`else
    v.push_back(mk(0, 1, 4'hF, 32'h0000ABCD, 32'h48, 32'hCAFEF00D, 0));
    v.push_back(mk(0, 0, 4'h0, 32'h0, 32'h08, 32'h0000ABCD, 0));
    v.push_back(mk(0, 0, 4'h0, 32'h0, 32'h48, 32'h0000ABCD, 0));
`endif
    v.push_back(mk(1, 1, 4'hF, 32'h00000077, 32'h30, 32'h0, 0));
    v.push_back(mk(1, 0, 4'h0, 32'h0, 32'h30, 32'h00000077, 0));
    foreach (v[k]) xfer(v[k], $sformatf("vec%0d", k));
    n_ack = 0;
    repeat (3) begin
      @(negedge clk);
      if (w_ack) n_ack++;
    end
    chk("single ack", n_ack, 0);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; wem = 4'hF; din = 32'h5; addr = 32'h30; cs = 1'b1;
    @(negedge clk);
    chk("mid hold", {31'b0, w_hold}, 1);
    rstn = 1'b1; cs = 1'b0;
    @(negedge clk);
    chk("mid ack", {31'b0, w_ack}, 0);
    chk("mid err", {31'b0, w_err}, 0);
    chk("mid hold after", {31'b0, w_hold}, 0);
    chk("mid rdata", w_rdata, 0);
    rstn = 1'b0;
    xfer(mk(1, 0, 4'h0, 32'h0, 32'h30, 32'h00000077, 0), "after reset");
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
